// File: rtl/ad9643_user_pattern_checker.sv
// ad9643_user_pattern_checker
// Aligns to the AD9643 four-word user test pattern (pattern 1..4, repeating)
// in the deserialized ADC word stream, declares lock, and then flags and counts
// every word that breaks the sequence.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                checker active; low returns the FSM to IDLE
//   data_valid, data_in   captured 16-bit ADC word and its qualifier
//   user_pattern_1..4     expected pattern words, compared live (not latched)
//   clear_errors          synchronous clear of error_count and sticky_error
//   locked                sequence lock achieved
//   mismatch              one-cycle pulse per mismatching word while locked
//   error_count           saturating mismatch count while locked
//   sticky_error          set on any mismatch while locked, held until cleared
//   expected_index        index (0..3) of the next expected pattern word
//
// state  | meaning
// IDLE   | checker disabled, waiting for enable
// SEARCH | discarding words until one equals user_pattern_1
// VERIFY | aligned, counting fully matching sequences toward lock
// LOCKED | locked, flagging and counting mismatches
module ad9643_user_pattern_checker #(
  parameter int LOCK_CYCLES = 2,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             data_valid,
  input  logic [15:0]      data_in,
  input  logic [15:0]      user_pattern_1,
  input  logic [15:0]      user_pattern_2,
  input  logic [15:0]      user_pattern_3,
  input  logic [15:0]      user_pattern_4,
  input  logic             clear_errors,
  output logic             locked,
  output logic             mismatch,
  output logic [CNT_W-1:0] error_count,
  output logic             sticky_error,
  output logic [1:0]       expected_index
);

  localparam int GW = $clog2(LOCK_CYCLES + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CYCLES);
  localparam logic [EW-1:0] LOSS_V = EW'(LOSS_THRESH);

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       idx_n;
  logic [GW-1:0]    good_cycles, good_n, good_inc;
  logic [EW-1:0]    consec_err, consec_n, consec_inc;
  logic [CNT_W-1:0] count_n;
  logic             sticky_n, mismatch_n;
  logic [15:0]      expected_word;
  logic             word_match;

  always_comb begin
    expected_word = user_pattern_1;
    case (expected_index)
      2'd0: expected_word = user_pattern_1;
      2'd1: expected_word = user_pattern_2;
      2'd2: expected_word = user_pattern_3;
      2'd3: expected_word = user_pattern_4;
      default: expected_word = user_pattern_1;
    endcase
  end

  assign word_match = (data_in == expected_word);
  assign good_inc   = good_cycles + 1'b1;
  assign consec_inc = consec_err + 1'b1;

  always_comb begin
    state_n    = state;
    idx_n      = expected_index;
    good_n     = good_cycles;
    consec_n   = consec_err;
    count_n    = error_count;
    sticky_n   = sticky_error;
    mismatch_n = 1'b0;

    if (!enable) begin
      state_n  = IDLE;
      idx_n    = 2'd0;
      good_n   = '0;
      consec_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SEARCH;
          idx_n   = 2'd0;
        end
        SEARCH: begin
          if (data_valid && data_in == user_pattern_1) begin
            state_n = VERIFY;
            idx_n   = 2'd1;
            good_n  = '0;
          end
        end
        VERIFY: begin
          if (data_valid) begin
            if (word_match) begin
              idx_n = expected_index + 2'd1;
              if (expected_index == 2'd3) begin
                good_n = good_inc;
                if (good_inc == LOCK_V) begin
                  state_n  = LOCKED;
                  consec_n = '0;
                end
              end
            end else if (data_in == user_pattern_1) begin
              // The breaking word may itself be the start of a new sequence.
              idx_n  = 2'd1;
              good_n = '0;
            end else begin
              state_n = SEARCH;
              idx_n   = 2'd0;
              good_n  = '0;
            end
          end
        end
        LOCKED: begin
          if (data_valid) begin
            // Alignment is kept through errors so isolated bit flips don't slip.
            idx_n = expected_index + 2'd1;
            if (word_match) begin
              consec_n = '0;
            end else begin
              mismatch_n = 1'b1;
              sticky_n   = 1'b1;
              consec_n   = consec_inc;
              if (error_count != {CNT_W{1'b1}}) count_n = error_count + 1'b1;
              if (consec_inc == LOSS_V) begin
                state_n  = SEARCH;
                idx_n    = 2'd0;
                consec_n = '0;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Clear takes priority over a coincident mismatch; the pulse still fires.
    if (clear_errors) begin
      count_n  = '0;
      sticky_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      expected_index <= 2'd0;
      good_cycles    <= '0;
      consec_err     <= '0;
      error_count    <= '0;
      sticky_error   <= 1'b0;
      mismatch       <= 1'b0;
      locked         <= 1'b0;
    end else begin
      state          <= state_n;
      expected_index <= idx_n;
      good_cycles    <= good_n;
      consec_err     <= consec_n;
      error_count    <= count_n;
      sticky_error   <= sticky_n;
      mismatch       <= mismatch_n;
      locked         <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_ad9643_user_pattern_checker.sv
// Testbench for ad9643_user_pattern_checker: a reference model predicts the
// outputs for every driven word, the prediction is queued, and it is popped
// and compared after the clock edge that consumes the word.
module tb_ad9643_user_pattern_checker;

  localparam int CNT_W = 4;
  localparam int LOCK  = 2;
  localparam int LOSS  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             data_valid;
  logic [15:0]      data_in;
  logic [15:0]      user_pattern_1, user_pattern_2, user_pattern_3, user_pattern_4;
  logic             clear_errors;
  logic             locked;
  logic             mismatch;
  logic [CNT_W-1:0] error_count;
  logic             sticky_error;
  logic [1:0]       expected_index;

  ad9643_user_pattern_checker #(.LOCK_CYCLES(LOCK), .LOSS_THRESH(LOSS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_valid(data_valid),
    .data_in(data_in), .user_pattern_1(user_pattern_1), .user_pattern_2(user_pattern_2),
    .user_pattern_3(user_pattern_3), .user_pattern_4(user_pattern_4),
    .clear_errors(clear_errors), .locked(locked), .mismatch(mismatch),
    .error_count(error_count), .sticky_error(sticky_error), .expected_index(expected_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l; int m; int c; int s; int i;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] pat[4];
  int          sp;

  // reference model state: 0 idle, 1 search, 2 verify, 3 locked
  int m_st, m_idx, m_good, m_cerr, m_cnt, m_sticky, m_mis;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_good = 0; m_cerr = 0; m_cnt = 0; m_sticky = 0; m_mis = 0;
  endtask

  task automatic model_step(input logic en, input logic v, input logic [15:0] d, input logic clr);
    m_mis = 0;
    if (!en) begin
      m_st = 0; m_idx = 0; m_good = 0; m_cerr = 0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_idx = 0; end
        1: if (v && d == pat[0]) begin m_st = 2; m_idx = 1; m_good = 0; end
        2: if (v) begin
             if (d == pat[m_idx]) begin
               if (m_idx == 3) begin
                 m_good++;
                 if (m_good == LOCK) begin m_st = 3; m_cerr = 0; end
               end
               m_idx = (m_idx + 1) % 4;
             end else if (d == pat[0]) begin
               m_idx = 1; m_good = 0;
             end else begin
               m_st = 1; m_idx = 0; m_good = 0;
             end
           end
        default: if (v) begin
             if (d != pat[m_idx]) begin
               m_mis = 1; m_sticky = 1; m_cerr++;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
             end else begin
               m_cerr = 0;
             end
             m_idx = (m_idx + 1) % 4;
             if (m_cerr == LOSS) begin m_st = 1; m_cerr = 0; m_idx = 0; end
           end
      endcase
    end
    if (clr) begin m_cnt = 0; m_sticky = 0; end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic clr);
    exp_t e;
    @(negedge clk);
    data_valid = v; data_in = d; clear_errors = clr;
    model_step(enable, v, d, clr);
    e.l = (m_st == 3); e.m = m_mis; e.c = m_cnt; e.s = m_sticky; e.i = m_idx;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("locked", locked, e.l);
      chk("mismatch", mismatch, e.m);
      chk("error_count", error_count, e.c);
      chk("sticky_error", sticky_error, e.s);
      chk("expected_index", expected_index, e.i);
    end
    data_valid = 1'b0; clear_errors = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, pat[sp], 1'b0);
      sp = (sp + 1) % 4;
    end
  endtask

  task automatic bad_word(input logic clr);
    drive(1'b1, 16'h0000, clr);
    sp = (sp + 1) % 4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 16'hA5A5; pat[1] = 16'h5A5A; pat[2] = 16'h1234; pat[3] = 16'hFFFF;
    user_pattern_1 = pat[0]; user_pattern_2 = pat[1];
    user_pattern_3 = pat[2]; user_pattern_4 = pat[3];
    enable = 1'b0; data_valid = 1'b0; data_in = '0; clear_errors = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    chk("rst_locked", locked, 0);
    chk("rst_count", error_count, 0);
    chk("rst_index", expected_index, 0);
    #20;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;

    // aligned stream: locks after the 8th word, index walks 1,2,3,0
    drive(1'b0, 16'h0000, 1'b0);
    sp = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, pat[sp], 1'b0);
      sp = (sp + 1) % 4;
      chk("lock_latency_a", locked, (k >= 8) ? 1 : 0);
      chk("index_walk", expected_index, k % 4);
    end
    chk("no_errors", error_count, 0);

    // disable from LOCKED, then a stream starting at pattern 3
    enable = 1'b0;
    drive(1'b1, pat[sp], 1'b0);
    chk("disable_unlock", locked, 0);
    enable = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    sp = 2;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, pat[sp], 1'b0);
      sp = (sp + 1) % 4;
      chk("lock_latency_b", locked, (k >= 10) ? 1 : 0);
    end

    // single corrupted 0x5A5A word
    while (sp != 1) stream(1);
    bad_word(1'b0);
    chk("single_mismatch", mismatch, 1);
    chk("single_count", error_count, 1);
    chk("single_sticky", sticky_error, 1);
    chk("single_locked", locked, 1);
    chk("single_index", expected_index, 2);
    stream(1);
    chk("pulse_width", mismatch, 0);
    stream(3);

    // three consecutive bad words drop lock, then relock
    bad_word(1'b0);
    bad_word(1'b0);
    chk("loss_pending", locked, 1);
    bad_word(1'b0);
    chk("loss_locked", locked, 0);
    chk("loss_count", error_count, 4);
    stream(16);
    chk("relock", locked, 1);

    // isolated errors saturate the 4-bit counter
    for (int r = 0; r < 20; r++) begin
      stream(3);
      bad_word(1'b0);
    end
    chk("saturate", error_count, 15);
    chk("sat_locked", locked, 1);
    stream(1);
    bad_word(1'b1);
    chk("clr_pulse", mismatch, 1);
    chk("clr_count", error_count, 0);
    chk("clr_sticky", sticky_error, 0);

    // gaps in data_valid must not disturb anything
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, 16'hDEAD, 1'b0);
      else stream(1);
    end
    bad_word(1'b0);
    stream(4);

    // asynchronous reset between edges
    reset = 1'b1;
    #1;
    chk("async_locked", locked, 0);
    chk("async_count", error_count, 0);
    chk("async_sticky", sticky_error, 0);
    chk("async_index", expected_index, 0);
    model_reset();
    #1;
    reset = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    sp = 3;
    stream(1);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, pat[sp], 1'b0);
      sp = (sp + 1) % 4;
      chk("relock_after_reset", locked, (k >= 8) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
